pmem_line_responder: RTL and testbench

//  Memory-side responder for the cache's 128-bit line interface (pmem_*). Accepts
//  one line read or line write at a time from the cache miss/write-back path.

---
 rtl/pmem_line_if.sv | 23 ++
 rtl/pmem_line_responder.sv | 85 ++++++++
 tb/tb_pmem_line_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pmem_line_if.sv
// Cache-to-memory 128-bit line bus. The cache drives requests and the memory side
// drives the response.
interface pmem_line_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  // Handshake: the requester raises pmem_read or pmem_write and holds it until
  // pmem_resp pulses for one cycle. It drops the request in that cycle, or the
  // request is accepted again. Dropping the request early aborts the transfer.
  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_line_responder.sv
// Memory-side responder for the cache line bus: one read or write at a time,
// completed after LATENCY cycles from a local line array.
module pmem_line_responder #(
  parameter int LATENCY = 4,
  parameter int INDEX_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  pmem_line_if.slave bus,
  output logic       busy,
  output logic       proto_err,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  logic [1:0]         state;
  logic [7:0]         counter;
  logic               op_write;
  logic [INDEX_W-1:0] idx;
  logic [127:0]       wdata_q;
  logic [127:0]       rdata_q;
  logic               resp_q;
  logic               req_live;
  logic               finish;
  logic [127:0]       mem [2**INDEX_W];

  // The latched op decides which request line must stay high to keep the transfer alive.
  assign req_live = op_write ? bus.pmem_write : bus.pmem_read;
  assign finish   = (state == S_BUSY) && req_live && (counter == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      counter   <= 8'd0;
      op_write  <= 1'b0;
      idx       <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.pmem_read || bus.pmem_write) begin
            op_write <= bus.pmem_write;
            idx      <= bus.pmem_address[INDEX_W+3:4];
            wdata_q  <= bus.pmem_wdata;
            counter  <= LAT_M1;
            state    <= S_BUSY;
            if (bus.pmem_read && bus.pmem_write) proto_err <= 1'b1;
          end
        end
        S_BUSY: begin
          if (!req_live) begin
            state <= S_IDLE;
          end else if (counter == 8'd0) begin
            state  <= S_RESP;
            resp_q <= 1'b1;
            if (!op_write) rdata_q <= mem[idx];
          end else begin
            counter <= counter - 8'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The array has no reset. A reset during BUSY discards the pending write.
  always_ff @(posedge clk) begin
    if (!reset && finish && op_write) mem[idx] <= wdata_q;
  end

  assign busy           = (state == S_BUSY) || (state == S_RESP);
  assign fsm_state      = state;
  assign bus.pmem_rdata = rdata_q;
  assign bus.pmem_resp  = resp_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_pmem_line_responder;

  localparam int LAT_A = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy_a, proto_err_a, busy_b, proto_err_b;
  logic [1:0] state_a, state_b;
  int         checks = 0;
  int         fails  = 0;

  pmem_line_if ifa ();
  pmem_line_if ifb ();

  pmem_line_responder #(.LATENCY(LAT_A), .INDEX_W(6)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave),
    .busy(busy_a), .proto_err(proto_err_a), .fsm_state(state_a)
  );

  pmem_line_responder #(.LATENCY(1), .INDEX_W(6)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave),
    .busy(busy_b), .proto_err(proto_err_b), .fsm_state(state_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with dut_a idle; returns #1 after the edge following resp.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [127:0] data,
                        output logic [127:0] rdata_seen);
    int edges;
    ifa.pmem_read    = rd;
    ifa.pmem_write   = wr;
    ifa.pmem_address = addr;
    ifa.pmem_wdata   = data;
    @(posedge clk); #1;
    check({tag, "_busy"}, busy_a, 1'b1);
    edges = 0;
    while (edges < 300) begin
      @(posedge clk); #1;
      edges++;
      if (ifa.pmem_resp) break;
    end
    check({tag, "_latency"}, edges, LAT_A);
    rdata_seen       = ifa.pmem_rdata;
    ifa.pmem_read    = 1'b0;
    ifa.pmem_write   = 1'b0;
    ifa.pmem_address = 16'h0;
    @(posedge clk); #1;
    check({tag, "_resp_low"}, ifa.pmem_resp, 1'b0);
  endtask

  localparam logic [127:0] W1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DA = 128'hAAAA5555AAAA5555AAAA5555AAAA5555;
  localparam logic [127:0] DP = 128'h11112222333344445555666677778888;
  localparam logic [127:0] DB = 128'hBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBB;
  localparam logic [127:0] DC = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
  localparam logic [127:0] DO = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] DD = 128'hDDDDDDDDDDDDDDDDDDDDDDDDDDDDDDDD;
  localparam logic [127:0] DE = 128'hE0E0E0E0E0E0E0E0E0E0E0E0E0E0E0E0;

  initial begin
    logic [127:0] rd;
    logic         resp_seen;
    logic [8:0]   pattern;
    logic [8:0]   exp_pattern;

    reset = 1'b1;
    ifa.pmem_read = 1'b0; ifa.pmem_write = 1'b0; ifa.pmem_address = '0; ifa.pmem_wdata = '0;
    ifb.pmem_read = 1'b0; ifb.pmem_write = 1'b0; ifb.pmem_address = '0; ifb.pmem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp", ifa.pmem_resp, 1'b0);
    check("rst_rdata", ifa.pmem_rdata, 128'h0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_proto_err", proto_err_a, 1'b0);
    check("rst_state", state_a, 2'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Write then read back
    do_req("t1_wr", 1'b0, 1'b1, 16'h0040, W1, rd);
    check("t1_proto_err", proto_err_a, 1'b0);
    do_req("t1_rd", 1'b1, 1'b0, 16'h0040, '0, rd);
    check("t1_rdata", rd, W1);
    check("t1_rdata_hold", ifa.pmem_rdata, W1);

    // Aliasing on bits outside [9:4]
    do_req("t2_wr", 1'b0, 1'b1, 16'h0010, DA, rd);
    do_req("t2_rd_0410", 1'b1, 1'b0, 16'h0410, '0, rd);
    check("t2_rdata_0410", rd, DA);
    do_req("t2_rd_001f", 1'b1, 1'b0, 16'h001F, '0, rd);
    check("t2_rdata_001f", rd, DA);

    // Abort: known contents first, then drop a write after two BUSY edges
    do_req("t3_prior", 1'b0, 1'b1, 16'h0080, DP, rd);
    ifa.pmem_write = 1'b1; ifa.pmem_address = 16'h0080; ifa.pmem_wdata = DB;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifa.pmem_write = 1'b0;
    resp_seen = 1'b0;
    @(posedge clk); #1;
    check("t3_abort_busy", busy_a, 1'b0);
    check("t3_abort_state", state_a, 2'd0);
    resp_seen = resp_seen | ifa.pmem_resp;
    repeat (6) begin
      @(posedge clk); #1;
      resp_seen = resp_seen | ifa.pmem_resp;
    end
    check("t3_no_resp", resp_seen, 1'b0);
    do_req("t3_rd", 1'b1, 1'b0, 16'h0080, '0, rd);
    check("t3_rdata_prior", rd, DP);

    // Read and write together: handled as a write, sticky error
    do_req("t4_both", 1'b1, 1'b1, 16'h0100, DC, rd);
    check("t4_proto_err", proto_err_a, 1'b1);
    do_req("t4_rd", 1'b1, 1'b0, 16'h0100, '0, rd);
    check("t4_rdata", rd, DC);
    check("t4_proto_err_sticky", proto_err_a, 1'b1);

    // Reset in the middle of BUSY
    do_req("t5_prior", 1'b0, 1'b1, 16'h0200, DO, rd);
    ifa.pmem_write = 1'b1; ifa.pmem_address = 16'h0200; ifa.pmem_wdata = DD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    ifa.pmem_write = 1'b0;
    @(posedge clk); #1;
    check("t5_resp", ifa.pmem_resp, 1'b0);
    check("t5_rdata", ifa.pmem_rdata, 128'h0);
    check("t5_busy", busy_a, 1'b0);
    check("t5_proto_err", proto_err_a, 1'b0);
    check("t5_state", state_a, 2'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    do_req("t5_rd", 1'b1, 1'b0, 16'h0200, '0, rd);
    check("t5_rdata_old", rd, DO);

    // LATENCY=1: single write, then a held read repeating every 3 cycles
    ifb.pmem_write = 1'b1; ifb.pmem_address = 16'h0050; ifb.pmem_wdata = DE;
    @(posedge clk); #1;
    check("t6_wr_accept_resp", ifb.pmem_resp, 1'b0);
    check("t6_wr_busy", busy_b, 1'b1);
    @(posedge clk); #1;
    check("t6_wr_resp", ifb.pmem_resp, 1'b1);
    ifb.pmem_write = 1'b0;
    @(posedge clk); #1;
    check("t6_wr_resp_low", ifb.pmem_resp, 1'b0);
    ifb.pmem_read = 1'b1;
    exp_pattern = 9'b010_010_010;
    pattern = '0;
    for (int i = 8; i >= 0; i--) begin
      @(posedge clk); #1;
      pattern[i] = ifb.pmem_resp;
      if (i == 7) check("t6_rdata", ifb.pmem_rdata, DE);
    end
    check("t6_resp_pattern", pattern, exp_pattern);
    ifb.pmem_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle", state_b, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
